sram_port_arb: RTL and testbench

SRAM_PORT_ARB -- requirements
Module: sram_port_arb

---
 rtl/sram_port_arb.sv | 111 +++++++++++
 tb/tb_sram_port_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arb.sv
// sram_port_arb: two requesters sharing one synchronous single-port SRAM.
// One grant per cycle, round-robin or fixed priority, 1-cycle read return.
module sram_port_arb #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic                  hclk_i,
  input  logic                  hrst_n_i,
  input  logic                  p0_en_i,
  input  logic                  p0_we_i,
  input  logic [3:0]            p0_wbe_i,
  input  logic [ADDR_BITS-1:0]  p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,
  input  logic                  p1_en_i,
  input  logic                  p1_we_i,
  input  logic [3:0]            p1_wbe_i,
  input  logic [ADDR_BITS-1:0]  p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,
  output logic                  sram_cs_o,
  output logic                  sram_we_o,
  output logic [3:0]            sram_wbe_o,
  output logic [ADDR_BITS-1:0]  sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  logic last_r;
  logic owner_r;
  logic rd_pend_r;
  logic w_g0;
  logic w_g1;
  logic w_gnt;
  logic w_rd;

  // last_r=1 means port 1 went last, so port 0 wins the next contention
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (hrst_n_i) begin
      if (p0_en_i && p1_en_i) begin
        if (ARB_MODE == 1 || last_r) begin
          w_g0 = 1'b1;
        end else begin
          w_g1 = 1'b1;
        end
      end else begin
        w_g0 = p0_en_i;
        w_g1 = p1_en_i;
      end
    end
  end

  assign p0_gnt_o = w_g0;
  assign p1_gnt_o = w_g1;
  assign w_gnt    = w_g0 | w_g1;
  assign w_rd     = w_gnt & ~sram_we_o;

  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_wbe_o   = 4'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    unique case (1'b1)
      w_g0: begin
        sram_cs_o    = 1'b1;
        sram_we_o    = p0_we_i;
        sram_wbe_o   = p0_we_i ? p0_wbe_i : 4'b0;
        sram_addr_o  = p0_addr_i;
        sram_wdata_o = p0_wdata_i;
      end
      w_g1: begin
        sram_cs_o    = 1'b1;
        sram_we_o    = p1_we_i;
        sram_wbe_o   = p1_we_i ? p1_wbe_i : 4'b0;
        sram_addr_o  = p1_addr_i;
        sram_wdata_o = p1_wdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hclk_i or negedge hrst_n_i) begin
    if (!hrst_n_i) begin
      last_r    <= 1'b1;
      owner_r   <= 1'b0;
      rd_pend_r <= 1'b0;
    end else begin
      rd_pend_r <= w_rd;
      if (w_gnt) begin
        last_r <= w_g1;
      end
      if (w_rd) begin
        owner_r <= w_g1;
      end
    end
  end

  assign p0_rvalid_o = rd_pend_r & ~owner_r;
  assign p1_rvalid_o = rd_pend_r & owner_r;
  assign p0_rdata_o  = {DATA_WIDTH{p0_rvalid_o}} & sram_rdata_i;
  assign p1_rdata_o  = {DATA_WIDTH{p1_rvalid_o}} & sram_rdata_i;

endmodule

// File: tb/tb_sram_port_arb.sv
// tb_sram_port_arb: round-robin and fixed-priority instances side by side,
// each with its own SRAM and a transaction-level reference model.
module tb_sram_port_arb;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct packed {
    logic          v;
    logic          we;
    logic [3:0]    wbe;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          p0_en[2], p1_en[2], p0_we[2], p1_we[2];
  logic [3:0]    p0_wbe[2], p1_wbe[2];
  logic [AW-1:0] p0_addr[2], p1_addr[2];
  logic [DW-1:0] p0_wdata[2], p1_wdata[2];
  logic          p0_gnt[2], p1_gnt[2], p0_rv[2], p1_rv[2];
  logic [DW-1:0] p0_rd[2], p1_rd[2];
  logic          cs[2], we[2];
  logic [3:0]    wbe[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wdata[2], srd[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_port_arb #(
      .ADDR_BITS (AW),
      .DATA_WIDTH(DW),
      .ARB_MODE  (g)
    ) u_dut (
      .hclk_i      (clk),
      .hrst_n_i    (rst_n),
      .p0_en_i     (p0_en[g]),
      .p0_we_i     (p0_we[g]),
      .p0_wbe_i    (p0_wbe[g]),
      .p0_addr_i   (p0_addr[g]),
      .p0_wdata_i  (p0_wdata[g]),
      .p0_gnt_o    (p0_gnt[g]),
      .p0_rvalid_o (p0_rv[g]),
      .p0_rdata_o  (p0_rd[g]),
      .p1_en_i     (p1_en[g]),
      .p1_we_i     (p1_we[g]),
      .p1_wbe_i    (p1_wbe[g]),
      .p1_addr_i   (p1_addr[g]),
      .p1_wdata_i  (p1_wdata[g]),
      .p1_gnt_o    (p1_gnt[g]),
      .p1_rvalid_o (p1_rv[g]),
      .p1_rdata_o  (p1_rd[g]),
      .sram_cs_o   (cs[g]),
      .sram_we_o   (we[g]),
      .sram_wbe_o  (wbe[g]),
      .sram_addr_o (addr[g]),
      .sram_wdata_o(wdata[g]),
      .sram_rdata_i(srd[g])
    );
  end

  req_t          rq[2][2];
  int            last_m[2], rown_m[2], win_m[2];
  bit            rdp_m[2];
  logic [DW-1:0] rexp_m[2];
  logic [DW-1:0] shadow[2][1024];
  logic [DW-1:0] mem[2][1024];
  bit            rnd;
  int            checks, errors;

  logic          s_g0[2], s_g1[2], s_rv0[2], s_rv1[2], s_cs[2], s_we[2];
  logic [3:0]    s_wbe[2];
  logic [AW-1:0] s_addr[2];
  logic [DW-1:0] s_wd[2], s_rd0[2], s_rd1[2];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      p0_en[d]    = rq[d][0].v;
      p0_we[d]    = rq[d][0].we;
      p0_wbe[d]   = rq[d][0].wbe;
      p0_addr[d]  = rq[d][0].addr;
      p0_wdata[d] = rq[d][0].wdata;
      p1_en[d]    = rq[d][1].v;
      p1_we[d]    = rq[d][1].we;
      p1_wbe[d]   = rq[d][1].wbe;
      p1_addr[d]  = rq[d][1].addr;
      p1_wdata[d] = rq[d][1].wdata;
    end
  endtask

  task automatic set_req(input int d, input int p, input logic w,
                         input logic [3:0] be, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
    req_t r;
    r.v = 1'b1;
    r.we = w;
    r.wbe = be;
    r.addr = a;
    r.wdata = wd;
    rq[d][p] = r;
    drive();
  endtask

  task automatic gen_rand();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        if (!rq[d][p].v && $urandom_range(0, 9) < 6)
          set_req(d, p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 15)),
                  $urandom);
  endtask

  task automatic cycle();
    req_t r;
    int   w;
    bit   e0, e1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      s_g0[d] = p0_gnt[d];  s_g1[d] = p1_gnt[d];
      s_rv0[d] = p0_rv[d];  s_rv1[d] = p1_rv[d];
      s_rd0[d] = p0_rd[d];  s_rd1[d] = p1_rd[d];
      s_cs[d] = cs[d];      s_we[d] = we[d];
      s_wbe[d] = wbe[d];    s_addr[d] = addr[d];
      s_wd[d] = wdata[d];
      w = -1;
      if (rst_n) begin
        if (rq[d][0].v && rq[d][1].v) w = (d == 1 || last_m[d] == 1) ? 0 : 1;
        else if (rq[d][0].v) w = 0;
        else if (rq[d][1].v) w = 1;
      end
      win_m[d] = w;
      r = (w >= 0) ? rq[d][w] : '0;
      e0 = rdp_m[d] && rown_m[d] == 0;
      e1 = rdp_m[d] && rown_m[d] == 1;
      chk($sformatf("d%0d gnt0", d), s_g0[d], w == 0);
      chk($sformatf("d%0d gnt1", d), s_g1[d], w == 1);
      chk($sformatf("d%0d cs", d), s_cs[d], w >= 0);
      chk($sformatf("d%0d we", d), s_we[d], r.we);
      chk($sformatf("d%0d wbe", d), s_wbe[d], r.we ? r.wbe : 4'h0);
      chk($sformatf("d%0d addr", d), s_addr[d], r.addr);
      chk($sformatf("d%0d wdata", d), s_wd[d], r.wdata);
      chk($sformatf("d%0d rv0", d), s_rv0[d], e0);
      chk($sformatf("d%0d rv1", d), s_rv1[d], e1);
      chk($sformatf("d%0d rd0", d), s_rd0[d], e0 ? rexp_m[d] : '0);
      chk($sformatf("d%0d rd1", d), s_rd1[d], e1 ? rexp_m[d] : '0);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      // SRAM behind the arbiter, driven from what the DUT presented
      if (s_cs[d]) begin
        if (s_we[d]) begin
          for (int b = 0; b < 4; b++)
            if (s_wbe[d][b]) mem[d][s_addr[d]][8*b +: 8] = s_wd[d][8*b +: 8];
        end else begin
          srd[d] = mem[d][s_addr[d]];
        end
      end
      w = win_m[d];
      rdp_m[d] = 1'b0;
      if (w >= 0) begin
        r = rq[d][w];
        if (r.we) begin
          for (int b = 0; b < 4; b++)
            if (r.wbe[b]) shadow[d][r.addr][8*b +: 8] = r.wdata[8*b +: 8];
        end else begin
          rdp_m[d]  = 1'b1;
          rown_m[d] = w;
          rexp_m[d] = shadow[d][r.addr];
        end
        last_m[d] = w;
        rq[d][w].v = 1'b0;
      end
    end
    #1;
    if (rnd) gen_rand();
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rdp_m[d] = 1'b0;
      last_m[d] = 1;
      for (int p = 0; p < 2; p++)
        set_req(d, p, 1'($urandom_range(0, 1)), 4'hF, 10'(p), $urandom);
    end
    cycle();
    for (int d = 0; d < 2; d++) begin
      chk("rst rv0", s_rv0[d], 1'b0);
      chk("rst rv1", s_rv1[d], 1'b0);
    end
    cycle();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) rq[d][p] = '0;
    drive();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++)
      if (rq[0][0].v || rq[0][1].v || rq[1][0].v || rq[1][1].v) cycle();
    cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rnd = 1'b0;
    for (int d = 0; d < 2; d++) begin
      srd[d] = '0;
      rown_m[d] = 0;
      rexp_m[d] = '0;
      for (int i = 0; i < 1024; i++) begin
        mem[d][i] = 32'(i) * 32'h0101_0101;
        shadow[d][i] = 32'(i) * 32'h0101_0101;
      end
      for (int p = 0; p < 2; p++) rq[d][p] = '0;
    end
    drive();
    do_reset();

    // p0 write then read back
    set_req(0, 0, 1'b1, 4'hF, 10'h005, 32'hDEAD_BEEF);
    cycle();
    chk("wr gnt0", s_g0[0], 1'b1);
    set_req(0, 0, 1'b0, 4'h0, 10'h005, '0);
    cycle();
    chk("rd gnt0", s_g0[0], 1'b1);
    cycle();
    chk("rd rv0", s_rv0[0], 1'b1);
    chk("rd data", s_rd0[0], 32'hDEAD_BEEF);
    chk("rd rv1", s_rv1[0], 1'b0);

    // round-robin alternation under continuous reads
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (!rq[0][0].v) set_req(0, 0, 1'b0, 4'hF, 10'(i), '0);
      if (!rq[0][1].v) set_req(0, 1, 1'b0, 4'h0, 10'(16 + i), '0);
      cycle();
      chk("rr gnt0", s_g0[0], (i % 2) == 0);
      chk("rr gnt1", s_g1[0], (i % 2) == 1);
      chk("rr rv0", s_rv0[0], i > 0 && (i % 2) == 1);
      chk("rr rv1", s_rv1[0], i > 0 && (i % 2) == 0);
    end
    drain();

    // fixed priority holds off port 1 until port 0 goes idle
    for (int i = 0; i < 4; i++) begin
      if (!rq[1][0].v) set_req(1, 0, 1'b0, 4'h0, 10'(i), '0);
      if (!rq[1][1].v) set_req(1, 1, 1'b0, 4'h0, 10'(8), '0);
      cycle();
      chk("fp gnt0", s_g0[1], 1'b1);
      chk("fp gnt1", s_g1[1], 1'b0);
    end
    cycle();
    chk("fp late gnt1", s_g1[1], 1'b1);
    drain();

    // partial byte write over all-ones
    mem[0][1023] = 32'hFFFF_FFFF;
    shadow[0][1023] = 32'hFFFF_FFFF;
    set_req(0, 1, 1'b1, 4'h3, 10'h3FF, 32'h0000_A5A5);
    cycle();
    chk("bw wbe", s_wbe[0], 4'h3);
    set_req(0, 1, 1'b0, 4'hF, 10'h3FF, '0);
    cycle();
    chk("bw rd wbe", s_wbe[0], 4'h0);
    chk("bw rd gnt1", s_g1[0], 1'b1);
    cycle();
    chk("bw rv1", s_rv1[0], 1'b1);
    chk("bw data", s_rd1[0], 32'hFFFF_A5A5);

    // reset right after a read grant
    set_req(0, 0, 1'b0, 4'h0, 10'h005, '0);
    set_req(1, 0, 1'b0, 4'h0, 10'h005, '0);
    cycle();
    chk("mr gnt0", s_g0[0], 1'b1);
    do_reset();
    cycle();
    chk("mr stale rv0", s_rv0[0], 1'b0);
    set_req(0, 0, 1'b0, 4'h0, 10'h001, '0);
    set_req(0, 1, 1'b0, 4'h0, 10'h002, '0);
    cycle();
    chk("mr post gnt0", s_g0[0], 1'b1);
    chk("mr post gnt1", s_g1[0], 1'b0);
    drain();

    // idle
    cycle();
    for (int d = 0; d < 2; d++) begin
      chk("idle cs", s_cs[d], 1'b0);
      chk("idle addr", s_addr[d], '0);
      chk("idle wdata", s_wd[d], '0);
      chk("idle gnt", {s_g0[d], s_g1[d]}, 2'b00);
    end

    rnd = 1'b1;
    repeat (3000) cycle();
    rnd = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
